cog_ctr_seq: RTL
================

Name: cog_ctr_seq

Overview:
Sample sequencer that feeds the cog counter's frequency register. The cog pushes 32-bit FRQ samples into a small FIFO. A programmable interval timer pops one sample per interval and drives setfrq/data of the counter, so the counter NCO/DUTY output plays a waveform without per-sample cog intervention. It sits between the cog's register-write decode and the counter block, on the counter's setfrq/data path.

Parameters:
DEPTH, 8, FIFO entries; power of two, 2..64.
AW, 3, log2(DEPTH); pointer width.

Ports:
clk_cog  in  1  cog clock; all state changes on its rising edge.
res  in  1  synchronous, active-high reset.
ena  in  1  cog enabled; low acts as a synchronous clear, same effect as res.
wr_cfg  in  1  write config from data: data[15:0] = period, data[16] = run, data[17] = hold.
wr_dat  in  1  push data[31:0] into the FIFO.
data  in  32  write data shared by wr_cfg and wr_dat.
setfrq  out  1  one-cycle pulse; counter loads frq from frq_data.
frq_data  out  32  sample being delivered; valid while setfrq = 1, holds last value otherwise.
full  out  1  count == DEPTH.
empty  out  1  count == 0.
count  out  AW+1  number of FIFO entries.
underrun  out  1  sticky: a tick found the FIFO empty.
overflow  out  1  sticky: a push was dropped because the FIFO was full.
running  out  1  current value of the run bit.

Behaviour:
- Reset (res = 1 or ena = 0):
  - pointers, count, period, run, hold, timer, underrun, overflow and setfrq all go to 0; frq_data goes to 0.
  - FIFO storage is not cleared.
  - res has priority over every other input in the same cycle.
- Config write (wr_cfg):
  - loads period, run and hold.
  - clears underrun and overflow.
  - loads timer <= data[15:0].
  - FIFO contents are untouched.
- States: IDLE (run = 0) and RUN (run = 1).
  - IDLE: timer holds its value; no ticks; setfrq = 0; pushes are still accepted.
  - RUN, each cycle: if timer == 0 then tick and timer <= period, else timer <= timer - 1.
  - Tick interval is period + 1 cycles. period = 0 gives a tick every cycle.
  - The first tick occurs period + 1 cycles after the wr_cfg edge.
- Tick with FIFO non-empty:
  - pop the head; on the same edge, frq_data <= head and setfrq <= 1.
  - setfrq is high for exactly the following cycle. Latency from tick cycle to setfrq is 1.
- Tick with FIFO empty:
  - underrun <= 1.
  - hold = 0: no setfrq pulse.
  - hold = 1: setfrq <= 1 with frq_data unchanged, re-delivering the last sample.
- Push (wr_dat):
  - accepted if count < DEPTH, or if a pop happens in the same cycle.
  - otherwise the data is dropped and overflow <= 1.
  - A pushed entry is poppable from the next cycle on. There is no bypass: a push into an empty FIFO in a tick cycle is stored, and the tick counts as an underrun.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointer and count arithmetic:
  - pointers are AW bits and wrap modulo DEPTH.
  - count is AW+1 bits and never exceeds DEPTH or goes below 0.
- wr_cfg and a tick in the same cycle: wr_cfg wins. No pop, timer reloads from data.
- wr_cfg and wr_dat in the same cycle: both take effect. The push is checked against the pre-write count; an overflow set by that push survives the clear.
- run 1 -> 0: ticks stop immediately. A setfrq already registered from the previous cycle still completes.
- All outputs are registered except full, empty and running, which are decoded from registers.

Test Plan:
- Reset → count = 0, empty = 1, full = 0, setfrq = 0, frq_data = 0, underrun = overflow = 0; assert res mid-RUN with 3 entries queued → same state on the next cycle.
- Push 0x11, 0x22, 0x33; wr_cfg period = 3, run = 1 → setfrq high exactly 5, 9 and 13 cycles after the wr_cfg edge, with frq_data 0x11, 0x22, 0x33; no other setfrq pulses.
- Push 0xA0; wr_cfg period = 0, run = 1, hold = 0 → one pulse carrying 0xA0; next tick sets underrun and gives no pulse. Repeat with hold = 1 → setfrq every cycle, frq_data held at 0xA0.
- DEPTH = 8, run = 0: push 9 words → count = 8, full = 1, overflow = 1, 9th word absent. Then run with period = 0 → the 8 pulses carry words 1..8 in order and pointers wrap cleanly.
- FIFO full, run with period = 0, push on every cycle → no overflow, count stays 8, output order equals push order across 20 samples.
- Tick coincident with wr_cfg (period = 5) → no pop, count unchanged, next tick 6 cycles later, underrun and overflow cleared.

Source files
------------

// File: rtl/cog_ctr_seq_if.sv
// Cog-side write/status bundle for the counter sample sequencer.
// The cog (master) writes config and samples; the sequencer (slave) reports FIFO and delivery state.
interface cog_ctr_seq_if #(
  parameter int AW = 3
);
  logic        wr_cfg;
  logic        wr_dat;
  logic [31:0] data;
  logic        setfrq;
  logic [31:0] frq_data;
  logic        full;
  logic        empty;
  logic [AW:0] count;
  logic        underrun;
  logic        overflow;
  logic        running;

  modport master (
    output wr_cfg, wr_dat, data,
    input  setfrq, frq_data, full, empty, count, underrun, overflow, running
  );

  modport slave (
    input  wr_cfg, wr_dat, data,
    output setfrq, frq_data, full, empty, count, underrun, overflow, running
  );
endinterface

// File: rtl/cog_ctr_seq.sv
// Sample sequencer: buffers cog-written FRQ samples in a FIFO and pops one per timer
// interval onto the counter's setfrq/frq_data load path.
module cog_ctr_seq #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk_cog,
  input  logic          res,
  input  logic          ena,
  cog_ctr_seq_if.slave  bus
);
  localparam logic [0:0]  ST_IDLE   = 1'b0;
  localparam logic [0:0]  ST_RUN    = 1'b1;
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW:0]   count_reg;
  logic [15:0]   period_reg;
  logic [15:0]   timer_reg;
  logic [0:0]    state_reg;
  logic          hold_reg;
  logic          underrun_reg;
  logic          overflow_reg;
  logic          setfrq_reg;
  logic [31:0]   frq_data_reg;

  logic clear;
  logic fifo_empty;
  logic fifo_full;
  logic tick;
  logic pop;
  logic push_ok;
  logic push_drop;

  // A disabled cog behaves exactly like a reset.
  assign clear      = res | ~ena;
  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == DEPTH_CNT);
  // A config write in the tick cycle takes over: no pop, timer reloads from data.
  assign tick       = (state_reg == ST_RUN) && (timer_reg == '0) && !bus.wr_cfg;
  assign pop        = tick && !fifo_empty;
  assign push_ok    = bus.wr_dat && (!fifo_full || pop);
  assign push_drop  = bus.wr_dat && !push_ok;

  // Storage is deliberately left out of the clear so it maps onto plain block RAM.
  always_ff @(posedge clk_cog) begin
    if (!clear && push_ok) begin
      mem[wr_ptr_reg] <= bus.data;
    end
  end

  always_ff @(posedge clk_cog) begin
    if (clear) begin
      frq_data_reg <= '0;
    end else if (pop) begin
      frq_data_reg <= mem[rd_ptr_reg];
    end
  end

  always_ff @(posedge clk_cog) begin
    if (clear) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      period_reg   <= '0;
      timer_reg    <= '0;
      state_reg    <= ST_IDLE;
      hold_reg     <= 1'b0;
      underrun_reg <= 1'b0;
      overflow_reg <= 1'b0;
      setfrq_reg   <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + (AW + 1)'(1);
        2'b01:   count_reg <= count_reg - (AW + 1)'(1);
        default: count_reg <= count_reg;
      endcase

      // With hold set, an empty tick re-delivers the sample already on frq_data.
      setfrq_reg <= tick && (!fifo_empty || hold_reg);

      if (bus.wr_cfg) begin
        period_reg   <= bus.data[15:0];
        timer_reg    <= bus.data[15:0];
        state_reg    <= bus.data[16] ? ST_RUN : ST_IDLE;
        hold_reg     <= bus.data[17];
        underrun_reg <= 1'b0;
        overflow_reg <= push_drop;
      end else begin
        if (state_reg == ST_RUN) begin
          timer_reg <= tick ? period_reg : timer_reg - 16'd1;
        end
        if (tick && fifo_empty) begin
          underrun_reg <= 1'b1;
        end
        if (push_drop) begin
          overflow_reg <= 1'b1;
        end
      end
    end
  end

  assign bus.setfrq   = setfrq_reg;
  assign bus.frq_data = frq_data_reg;
  assign bus.full     = fifo_full;
  assign bus.empty    = fifo_empty;
  assign bus.count    = count_reg;
  assign bus.underrun = underrun_reg;
  assign bus.overflow = overflow_reg;
  assign bus.running  = (state_reg == ST_RUN);
endmodule
